// File: rtl/program_loader.sv
// Purpose: receives a framed host byte stream (length, payload, checksum) and loads it into the relay computer memory.
// Latency: loadMem rises on the edge that accepts a good checksum; cpu_run rises on the edge after loadMemComplete.
// Backpressure: in_ready is high only in RX_LEN/RX_DATA/RX_SUM; the host holds its byte otherwise.
module program_loader #(
  parameter int          MEM_BYTES = 15,
  parameter logic [7:0]  FILL      = 8'h00,
  parameter int          TIMEOUT   = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [MEM_BYTES*8-1:0] initial_memory,
  output logic                   loadMem,
  input  logic                   loadMemComplete,
  output logic                   cpu_run,
  output logic                   busy,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [3:0]             byte_count
);

  localparam int         TW      = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAX_LEN = 8'(MEM_BYTES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RX_LEN, RX_DATA, RX_SUM, LOAD, RUN, ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    img_q [MEM_BYTES];
  logic [7:0]    img_d [MEM_BYTES];
  logic [3:0]    len_q, len_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    err_q, err_d;
  logic          load_q, load_d;
  logic          run_q, run_d;
  logic          busy_q, busy_d;
  logic          error_q, error_d;
  logic          xfer;

  // in_ready is decoded straight from the state so the host sees it in the same cycle
  always_comb begin
    in_ready = (state_q == RX_LEN) || (state_q == RX_DATA) || (state_q == RX_SUM);
    xfer     = in_valid && in_ready;
  end

  // next-state and datapath updates for the frame receiver and load handshake
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    timer_d = timer_q;
    err_d   = err_q;
    load_d  = load_q;
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (start) begin
          state_d = RX_LEN;
          err_d   = 2'd0;
          cnt_d   = 4'd0;
          sum_d   = 8'd0;
          len_d   = 4'd0;
          load_d  = 1'b0;
          for (int i = 0; i < MEM_BYTES; i++) img_d[i] = FILL;
        end
      end
      RX_LEN: begin
        if (xfer) begin
          if (in_data != 8'd0 && in_data <= MAX_LEN) begin
            len_d   = in_data[3:0];
            state_d = RX_DATA;
          end else begin
            err_d   = 2'd1;
            state_d = ERROR;
          end
        end
      end
      RX_DATA: begin
        if (xfer) begin
          img_d[cnt_q] = in_data;
          cnt_d        = cnt_q + 4'd1;
          sum_d        = sum_q + in_data;
          // the length check guarantees the count stops exactly at len
          if (cnt_q + 4'd1 == len_q) state_d = RX_SUM;
        end
      end
      RX_SUM: begin
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d = LOAD;
            load_d  = 1'b1;
            timer_d = '0;
          end else begin
            err_d   = 2'd2;
            state_d = ERROR;
          end
        end
      end
      LOAD: begin
        // an acknowledgement in the final timer cycle still counts as success
        if (loadMemComplete) begin
          load_d  = 1'b0;
          state_d = RUN;
        end else if (timer_q == T_LAST) begin
          load_d  = 1'b0;
          err_d   = 2'd3;
          state_d = ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d   = (state_d == RUN);
    error_d = (state_d == ERROR);
    busy_d  = (state_d == RX_LEN) || (state_d == RX_DATA) ||
              (state_d == RX_SUM) || (state_d == LOAD);
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int i = 0; i < MEM_BYTES; i++) img_q[i] <= FILL;
      len_q   <= 4'd0;
      cnt_q   <= 4'd0;
      sum_q   <= 8'd0;
      timer_q <= '0;
      err_q   <= 2'd0;
      load_q  <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      load_q  <= load_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  // flatten the image so byte k sits at bits [8k +: 8]
  always_comb begin
    initial_memory = '0;
    for (int i = 0; i < MEM_BYTES; i++) initial_memory[i*8 +: 8] = img_q[i];
  end

  assign loadMem    = load_q;
  assign cpu_run    = run_q;
  assign busy       = busy_q;
  assign error      = error_q;
  assign err_code   = err_q;
  assign byte_count = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Purpose: directed self-checking bench for program_loader.
// Latency: inputs driven on the falling edge, outputs sampled 1ns after the rising edge.
// Backpressure: the host model holds each byte until in_ready is seen high.
module tb_program_loader;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [119:0] initial_memory;
  logic         loadMem;
  logic         loadMemComplete = 1'b0;
  logic         cpu_run, busy, error;
  logic [1:0]   err_code;
  logic [3:0]   byte_count;

  int total = 0;
  int bad   = 0;
  logic saw_load = 1'b0;
  logic [119:0] all_ff;

  program_loader dut (
    .clock(clock), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .initial_memory(initial_memory), .loadMem(loadMem),
    .loadMemComplete(loadMemComplete), .cpu_run(cpu_run),
    .busy(busy), .error(error), .err_code(err_code), .byte_count(byte_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (loadMem) saw_load <= 1'b1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one byte, optionally after an idle gap, and wait for it to be accepted
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("send_timeout", 128'd0, 128'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // assert the acknowledgement after n LOAD cycles, then return just after the edge that samples it
  task automatic ack_after(input int n);
    repeat (n) @(negedge clock);
    loadMemComplete = 1'b1;
    @(posedge clock);
    #1 loadMemComplete = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1 check("rst_loadmem", {127'd0, loadMem}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_image", {8'd0, initial_memory}, 128'd0);
    check("rst_count", {124'd0, byte_count}, 128'd0);
    check("rst_ready", {127'd0, in_ready}, 128'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int cyc;
    all_ff = '1;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_ready", {127'd0, in_ready}, 128'd0);
    check("reset_loadmem", {127'd0, loadMem}, 128'd0);
    check("reset_flags", {124'd0, cpu_run, busy, error, 1'b0}, 128'd0);
    check("reset_err", {126'd0, err_code}, 128'd0);
    check("reset_image", {8'd0, initial_memory}, 128'd0);
    @(negedge clock);
    reset = 1'b1;

    // start together with a valid byte: start wins, byte then becomes the length
    @(negedge clock);
    start = 1'b1; in_data = 8'h03; in_valid = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_ready", {127'd0, in_ready}, 128'd1);
    check("start_busy", {127'd0, busy}, 128'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    send(8'h11, 0); send(8'h22, 1); send(8'h33, 0);
    check("t1_count", {124'd0, byte_count}, 128'd3);
    check("t1_image", {8'd0, initial_memory}, 128'h332211);
    send(8'h66, 0);
    check("t1_loadmem", {127'd0, loadMem}, 128'd1);
    check("t1_busy_load", {127'd0, busy}, 128'd1);
    ack_after(4);
    check("t1_run", {127'd0, cpu_run}, 128'd1);
    check("t1_loadmem_drop", {127'd0, loadMem}, 128'd0);
    check("t1_busy_run", {127'd0, busy}, 128'd0);
    check("t1_image_hold", {8'd0, initial_memory}, 128'h332211);

    // bad lengths 0 and 16
    pulse_start();
    check("t2_run_drop", {127'd0, cpu_run}, 128'd0);
    check("t2_image_fill", {8'd0, initial_memory}, 128'd0);
    send(8'h00, 0);
    check("t2_err0", {125'd0, error, err_code}, 128'b101);
    check("t2_ready0", {127'd0, in_ready}, 128'd0);
    pulse_start();
    check("t2_err_clr", {125'd0, error, err_code}, 128'd0);
    send(8'h10, 0);
    check("t2_err16", {125'd0, error, err_code}, 128'b101);
    pulse_start();
    send(8'h01, 0); send(8'hAA, 0); send(8'hAA, 0);
    ack_after(1);
    check("t2_recover", {126'd0, cpu_run, error}, 128'b10);

    // checksum mismatch
    pulse_start();
    saw_load = 1'b0;
    send(8'h02, 0); send(8'h01, 0); send(8'h02, 0); send(8'h04, 0);
    check("t3_err", {125'd0, error, err_code}, 128'b110);
    repeat (3) @(posedge clock);
    #1 check("t3_no_load", {127'd0, saw_load}, 128'd0);

    // load timeout
    pulse_start();
    send(8'h01, 0); send(8'h05, 0); send(8'h05, 0);
    cyc = 0;
    while (loadMem && cyc < 1000) begin
      cyc++;
      @(posedge clock);
      #1;
    end
    check("t4_high_cycles", 128'(cyc), 128'd255);
    check("t4_err", {125'd0, error, err_code}, 128'b111);

    // full-length frame with gaps and checksum wrap
    pulse_start();
    send(8'h0F, 2);
    for (int i = 0; i < 15; i++) send(8'hFF, int'($urandom_range(0, 3)));
    check("t5_count", {124'd0, byte_count}, 128'd15);
    check("t5_image", {8'd0, initial_memory}, {8'd0, all_ff});
    send(8'hF1, 1);
    check("t5_loadmem", {127'd0, loadMem}, 128'd1);
    ack_after(2);
    check("t5_run", {127'd0, cpu_run}, 128'd1);

    // reset mid-frame and mid-load
    pulse_start();
    send(8'h05, 0); send(8'h01, 0); send(8'h02, 0);
    pulse_reset();
    pulse_start();
    send(8'h01, 0); send(8'h07, 0); send(8'h07, 0);
    pulse_reset();
    pulse_start();
    send(8'h02, 0); send(8'h09, 0); send(8'h08, 0); send(8'h11, 0);
    ack_after(3);
    check("t6_run", {127'd0, cpu_run}, 128'd1);
    check("t6_image", {8'd0, initial_memory}, 128'h0809);
    check("t6_err", {125'd0, error, err_code}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
